// File: rtl/brom_uart_loader.sv
// brom_uart_loader
//   Loads a firmware image from a framed UART byte stream into the 2Kx8 boot
//   RAM while holding the CPU in reset. If no frame starts before the idle
//   timeout, the CPU is released to run the image preset in the bitstream.
//
//   Frame: SYNC_BYTE, LEN_HI, LEN_LO, LEN data bytes (LEN = 1..2048),
//          [checksum byte when BROM_LOADER_CSUM_EN is defined].
//
//   Optional feature macro: BROM_LOADER_CSUM_EN
//     defined   - a trailing checksum byte C is expected, and the frame is
//                 accepted when (sum of data bytes + C) mod 256 == 0
//     undefined - no checksum byte; DONE follows the last data write
//
// Ports
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   rx_data    in   [7:0] received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   ram_ce     out  RAM clock enable (pulses with ram_wre)
//   ram_wre    out  RAM write enable
//   ram_ad     out  [10:0] RAM byte address
//   ram_din    out  [7:0] RAM write data
//   cpu_resetn out  low holds the CPU in reset
//   busy       out  a frame is being received
//   done       out  CPU released (sticky until resetn)
//   loaded     out  image written successfully (sticky)
//   err        out  last frame failed
`timescale 1ns/1ps

module brom_uart_loader #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 2700000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        ram_ce,
    output logic        ram_wre,
    output logic [10:0] ram_ad,
    output logic [7:0]  ram_din,
    output logic        cpu_resetn,
    output logic        busy,
    output logic        done,
    output logic        loaded,
    output logic        err
);

    localparam int                CNT_W      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [15:0]       LEN_MAX    = 16'd2048;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef BROM_LOADER_CSUM_EN
        S_CSUM,
`endif
        S_ERR,
        S_DONE
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       len_hi_q;
    logic [15:0]      len_q;
    logic [10:0]      addr_q;
`ifdef BROM_LOADER_CSUM_EN
    logic [7:0]       sum_q;
    logic [7:0]       csum_chk;
`endif

    // write stage registers
    logic             wr_vld_p1;
    logic [10:0]      ram_ad_p1;
    logic [7:0]       ram_din_p1;
    logic             fin_vld_p1;

    logic             done_q, loaded_q, err_q;

    logic             tmo;
    logic             wr_en;
    logic             fin_en;
    logic             skip;
    logic [15:0]      len_full;
    logic             len_ok;
    logic             last_data;

    assign len_full  = {len_hi_q, rx_data};
    assign len_ok    = (len_full != 16'd0) && (len_full <= LEN_MAX);
    // LEN <= 2048, so LEN-1 always fits the 11-bit address.
    assign last_data = ({5'd0, addr_q} == (len_q - 16'd1));
    // An arriving byte always beats a simultaneous expiry.
    assign tmo       = (cnt_q == '0) && !rx_valid;
`ifdef BROM_LOADER_CSUM_EN
    assign csum_chk  = sum_q + rx_data;
`endif

    always_comb begin
        state_nxt = state_q;
        wr_en     = 1'b0;
        fin_en    = 1'b0;
        skip      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_nxt = S_LEN_HI;
                end else if (tmo) begin
                    state_nxt = S_DONE;
                    skip      = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (rx_valid)  state_nxt = S_LEN_LO;
                else if (tmo)  state_nxt = S_ERR;
            end
            S_LEN_LO: begin
                if (rx_valid)  state_nxt = len_ok ? S_DATA : S_ERR;
                else if (tmo)  state_nxt = S_ERR;
            end
            S_DATA: begin
                if (rx_valid) begin
                    wr_en = 1'b1;
                    if (last_data) begin
`ifdef BROM_LOADER_CSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_DONE;
                        fin_en    = 1'b1;
`endif
                    end
                end else if (tmo) begin
                    state_nxt = S_ERR;
                end
            end
`ifdef BROM_LOADER_CSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    if (csum_chk == 8'h00) begin
                        state_nxt = S_DONE;
                        fin_en    = 1'b1;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end else if (tmo) begin
                    state_nxt = S_ERR;
                end
            end
`endif
            S_ERR: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_nxt = S_LEN_HI;
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_RELOAD;
            len_hi_q   <= 8'd0;
            len_q      <= 16'd0;
            addr_q     <= 11'd0;
`ifdef BROM_LOADER_CSUM_EN
            sum_q      <= 8'd0;
`endif
            wr_vld_p1  <= 1'b0;
            ram_ad_p1  <= 11'd0;
            ram_din_p1 <= 8'd0;
            fin_vld_p1 <= 1'b0;
            done_q     <= 1'b0;
            loaded_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_nxt;

            // Reload on any byte and on every state change.
            if (rx_valid || (state_nxt != state_q)) cnt_q <= CNT_RELOAD;
            else if (cnt_q != '0)                    cnt_q <= cnt_q - CNT_W'(1);

            if (state_q == S_LEN_HI && rx_valid) len_hi_q <= rx_data;
            if (state_q == S_LEN_LO && rx_valid) len_q    <= len_full;

            // A new frame header (from IDLE or ERR) restarts address and sum.
            if (state_nxt == S_LEN_HI && state_q != S_LEN_HI) begin
                addr_q <= 11'd0;
`ifdef BROM_LOADER_CSUM_EN
                sum_q  <= 8'd0;
`endif
            end else if (wr_en) begin
                addr_q <= addr_q + 11'd1;
`ifdef BROM_LOADER_CSUM_EN
                sum_q  <= csum_chk;
`endif
            end

            // ---- stage p1: RAM write pulse, completion one cycle later ----
            wr_vld_p1 <= wr_en;
            if (wr_en) begin
                ram_ad_p1  <= addr_q;
                ram_din_p1 <= rx_data;
            end
            fin_vld_p1 <= fin_en;

            // ---- stage p2: sticky status ----
            if (fin_vld_p1 || skip) done_q   <= 1'b1;
            if (fin_vld_p1)         loaded_q <= 1'b1;
            err_q <= (state_nxt == S_ERR);
        end
    end

    assign ram_ce     = wr_vld_p1;
    assign ram_wre    = wr_vld_p1;
    assign ram_ad     = ram_ad_p1;
    assign ram_din    = ram_din_p1;
    assign cpu_resetn = done_q;
    assign done       = done_q;
    assign loaded     = loaded_q;
    assign err        = err_q;
`ifdef BROM_LOADER_CSUM_EN
    assign busy = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                  (state_q == S_DATA)   || (state_q == S_CSUM);
`else
    assign busy = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                  (state_q == S_DATA);
`endif

endmodule
